// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision add arbiter: FSM states,
// exponent limits, canonical encodings and the packed result bundle.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4,
    RESP  = 3'd5
  } fsm_state_t;

  localparam logic [7:0]  EXP_BIAS    = 8'd127;
  localparam logic [7:0]  EXP_MAX     = 8'd255;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic [31:0] bits;
    logic        ovf;
    logic        unf;
  } fp_res_t;

endpackage

// File: rtl/fp_add_core.sv
// Iterative single-precision adder datapath. The controlling FSM steps it
// through operand load, alignment, add and one-bit-per-cycle normalization.
module fp_add_core
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        align_en,
  input  logic        add_en,
  input  logic        norm_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        add_done,
  output logic        norm_last,
  output fp_res_t     res
);

  localparam logic signed [9:0] EXP_TOP = $signed({2'b00, EXP_MAX});

  // Saturating pack: infinities and exponent overflow clamp to signed inf,
  // exponent underflow flushes to signed zero, exact zero is always +0.
  function automatic fp_res_t pack_sat(
    input logic               sign,
    input logic signed [9:0]  exp,
    input logic [23:0]        mag,
    input logic               inf,
    input logic               inf_sign
  );
    fp_res_t r;
    r.bits = FP_POS_ZERO;
    r.ovf  = 1'b0;
    r.unf  = 1'b0;
    if (inf) begin
      r.bits = FP_POS_INF | {inf_sign, 31'd0};
      r.ovf  = 1'b1;
    end else if (mag == 24'd0) begin
      r.bits = FP_POS_ZERO;
    end else if (exp >= EXP_TOP) begin
      r.bits = FP_POS_INF | {sign, 31'd0};
      r.ovf  = 1'b1;
    end else if (exp <= 10'sd0) begin
      r.bits = {sign, 31'd0};
      r.unf  = 1'b1;
    end else begin
      r.bits = {sign, exp[7:0], mag[22:0]};
    end
    return r;
  endfunction

  logic [31:0]        op_a_p0, op_b_p0;
  logic               sign_big_p1, sign_sml_p1, inf_p1, inf_sign_p1;
  logic [23:0]        mant_big_p1, mant_sml_p1;
  logic signed [9:0]  exp_p1;
  logic               sign_p2;
  logic [23:0]        mag_p2;
  logic signed [9:0]  exp_p2;

  logic [7:0]         exp_a, exp_b, exp_big, exp_diff;
  logic [23:0]        mant_a, mant_b, mant_big, mant_sml, mant_sml_sh;
  logic               a_ge, sign_big, sign_sml, is_inf, inf_sign;

  // p0 -> p1: unpack and align the smaller-exponent operand
  always_comb begin
    exp_a       = op_a_p0[30:23];
    exp_b       = op_b_p0[30:23];
    mant_a      = (exp_a == 8'd0) ? 24'd0 : {1'b1, op_a_p0[22:0]};
    mant_b      = (exp_b == 8'd0) ? 24'd0 : {1'b1, op_b_p0[22:0]};
    a_ge        = (exp_a >= exp_b);
    exp_big     = a_ge ? exp_a : exp_b;
    exp_diff    = a_ge ? (exp_a - exp_b) : (exp_b - exp_a);
    mant_big    = a_ge ? mant_a : mant_b;
    mant_sml    = a_ge ? mant_b : mant_a;
    sign_big    = a_ge ? op_a_p0[31] : op_b_p0[31];
    sign_sml    = a_ge ? op_b_p0[31] : op_a_p0[31];
    mant_sml_sh = (exp_diff > 8'd24) ? 24'd0 : (mant_sml >> exp_diff);
    is_inf      = (exp_a == EXP_MAX) | (exp_b == EXP_MAX);
    inf_sign    = (exp_a == EXP_MAX) ? op_a_p0[31] : op_b_p0[31];
  end

  logic               eff_sub, big_ge, add_sign;
  logic [24:0]        sum;
  logic [23:0]        add_mag;
  logic signed [9:0]  add_exp;

  // p1 -> p2: sign-magnitude add, single carry renormalization
  always_comb begin
    eff_sub  = sign_big_p1 ^ sign_sml_p1;
    big_ge   = (mant_big_p1 >= mant_sml_p1);
    add_sign = big_ge ? sign_big_p1 : sign_sml_p1;
    if (!eff_sub)
      sum = {1'b0, mant_big_p1} + {1'b0, mant_sml_p1};
    else if (big_ge)
      sum = {1'b0, mant_big_p1} - {1'b0, mant_sml_p1};
    else
      sum = {1'b0, mant_sml_p1} - {1'b0, mant_big_p1};
    add_mag  = sum[24] ? sum[24:1] : sum[23:0];
    add_exp  = sum[24] ? (exp_p1 + 10'sd1) : exp_p1;
    add_done = inf_p1 | add_mag[23] | (add_mag == 24'd0);
  end

  always_ff @(posedge clk) begin
    if (load) begin
      op_a_p0 <= a;
      op_b_p0 <= b;
    end
    if (align_en) begin
      sign_big_p1 <= sign_big;
      sign_sml_p1 <= sign_sml;
      mant_big_p1 <= mant_big;
      mant_sml_p1 <= mant_sml_sh;
      exp_p1      <= $signed({2'b00, exp_big});
      inf_p1      <= is_inf;
      inf_sign_p1 <= inf_sign;
    end
    if (add_en) begin
      sign_p2 <= add_sign;
      mag_p2  <= add_mag;
      exp_p2  <= add_exp;
    end else if (norm_en) begin
      mag_p2  <= {mag_p2[22:0], 1'b0};
      exp_p2  <= exp_p2 - 10'sd1;
    end
  end

  // p2 -> result: normalization status and saturating pack
  always_comb begin
    norm_last = mag_p2[22];
    res       = pack_sat(sign_p2, exp_p2, mag_p2, inf_p1, inf_sign_p1);
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end sharing one iterative FP adder,
// with a held response until the consumer takes it.
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter logic PRIORITY_INIT = 1'b0
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_id,
  output logic        rsp_overflow,
  output logic        rsp_underflow,
  output logic        busy
);

  fsm_state_t  state_q, state_d;
  logic        ptr_q;
  logic        both, pick1, grant0, grant1, accept;
  logic [31:0] op_a, op_b;
  logic        align_en, add_en, norm_en;
  logic        core_add_done, core_norm_last;
  fp_res_t     core_res;

  // Grants are gated by rst_n so readies drop the instant reset asserts.
  always_comb begin
    both   = req0_valid & req1_valid;
    pick1  = both ? ptr_q : req1_valid;
    grant0 = rst_n & (state_q == IDLE) & req0_valid & ~pick1;
    grant1 = rst_n & (state_q == IDLE) & req1_valid & pick1;
    accept = grant0 | grant1;
    op_a   = grant1 ? req1_a : req0_a;
    op_b   = grant1 ? req1_b : req0_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = core_add_done ? PACK : NORM;
      NORM:    if (core_norm_last) state_d = PACK;
      PACK:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    align_en   = (state_q == ALIGN);
    add_en     = (state_q == ADD);
    norm_en    = (state_q == NORM);
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  // Pointer only rotates on contended grants; response fields latch in PACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= PRIORITY_INIT;
      rsp_id        <= 1'b0;
      rsp_result    <= FP_POS_ZERO;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
    end else begin
      if (accept && both)
        ptr_q <= ~ptr_q;
      if (accept)
        rsp_id <= grant1;
      if (state_q == PACK) begin
        rsp_result    <= core_res.bits;
        rsp_overflow  <= core_res.ovf;
        rsp_underflow <= core_res.unf;
      end
    end
  end

  fp_add_core u_core (
    .clk       (clk),
    .load      (accept),
    .align_en  (align_en),
    .add_en    (add_en),
    .norm_en   (norm_en),
    .a         (op_a),
    .b         (op_b),
    .add_done  (core_add_done),
    .norm_last (core_norm_last),
    .res       (core_res)
  );

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed vectors, randomized operands against an
// integer-arithmetic reference, arbitration order, response hold and reset.
module tb_fp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_underflow, busy;
  logic [31:0] rsp_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.PRIORITY_INIT(1'b0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req1_valid    (req1_valid),
    .req0_ready    (req0_ready),
    .req1_ready    (req1_ready),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_id        (rsp_id),
    .rsp_overflow  (rsp_overflow),
    .rsp_underflow (rsp_underflow),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer mantissas, truncating alignment, then
  // renormalize by plain magnitude comparisons.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ovf,
                                output logic unf, output int k);
    int ea, eb, e, d;
    longint ma, mb, vbig, vsml, s, mag;
    logic sg;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r = 32'd0; ovf = 1'b0; unf = 1'b0; k = 0;
    if (ea == 255 || eb == 255) begin
      sg = (ea == 255) ? a[31] : b[31];
      r = {sg, 8'hFF, 23'd0};
      ovf = 1'b1;
      return;
    end
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 8388608);
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + 8388608);
    if (ea >= eb) begin
      e = ea; d = ea - eb;
      vbig = a[31] ? -ma : ma;
      vsml = (d > 24) ? 0 : (mb >> d);
      vsml = b[31] ? -vsml : vsml;
    end else begin
      e = eb; d = eb - ea;
      vbig = b[31] ? -mb : mb;
      vsml = (d > 24) ? 0 : (ma >> d);
      vsml = a[31] ? -vsml : vsml;
    end
    s = vbig + vsml;
    if (s == 0) return;
    sg = (s < 0);
    mag = sg ? -s : s;
    while (mag >= 16777216) begin mag = mag >> 1; e++; end
    while (mag < 8388608) begin mag = mag << 1; e--; k++; end
    if (e >= 255) begin
      r = {sg, 8'hFF, 23'd0}; ovf = 1'b1;
    end else if (e <= 0) begin
      r = {sg, 31'd0}; unf = 1'b1;
    end else begin
      r = {sg, e[7:0], mag[22:0]};
    end
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] other);
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0:       v[30:23] = 8'd0;
      1:       v[30:23] = 8'hFF;
      2:       v[30:23] = 8'($urandom_range(250, 254));
      3:       v[30:23] = 8'($urandom_range(1, 3));
      4, 5:    v = {~other[31], other[30:0]} ^ 32'($urandom_range(0, 255));
      default: v[30:23] = 8'($urandom_range(110, 140));
    endcase
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge of cycle T+1.
  task automatic accept(input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        output int gid);
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    req0_valid = v0; req1_valid = v1;
    gid = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        gid = req1_ready ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (gid < 0)
      check("accept_ready", 32'(req0_ready | req1_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] er, input logic eo,
                          input logic eu, input int k, input logic eid);
    int lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(4 + k));
    check({tag, "_res"}, rsp_result, er);
    check({tag, "_flags"}, {30'd0, rsp_overflow, rsp_underflow}, {30'd0, eo, eu});
    check({tag, "_id"}, 32'(rsp_id), 32'(eid));
    if (rsp_ready) begin
      @(negedge clk);
      check({tag, "_idle"}, {30'd0, rsp_valid, busy}, 32'd0);
    end
  endtask

  task automatic run_exp(input string tag, input int id, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er,
                         input logic eo, input logic eu, input int k);
    int gid;
    accept(id == 0, id == 1, a, b, a, b, gid);
    check({tag, "_grant"}, 32'(gid), 32'(id));
    wait_rsp(tag, er, eo, eu, k, id[0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gid, ng, nr, hold_cnt;
    int gq[4];
    int rq[4];
    logic [31:0] resq[4];

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    req1_a = 32'd0; req1_b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctl", {25'd0, rsp_valid, busy, req0_ready, req1_ready,
                      rsp_id, rsp_overflow, rsp_underflow}, 32'd0);
    check("rst_res", rsp_result, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_exp("carry", 0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 0);
    run_exp("norm1", 1, 32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000, 1'b0, 1'b0, 1);
    run_exp("cancel", 1, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
    run_exp("ovf", 0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0, 0);
    run_exp("unf", 1, 32'h0080_0000, 32'h80C0_0000, 32'h8000_0000, 1'b0, 1'b1, 1);
    run_exp("inf_op", 0, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b1, 1'b0, 0);
    run_exp("zero_op", 1, 32'h0000_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0, 0);
    run_exp("far_shift", 0, 32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 1'b0, 1'b0, 0);
    run_exp("norm23", 1, 32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000, 1'b0, 1'b0, 23);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b, r;
      logic o, u;
      int k, id;
      a = rnd_op($urandom);
      b = rnd_op(a);
      model(a, b, r, o, u, k);
      id = int'($urandom_range(0, 1));
      run_exp($sformatf("rnd%0d", i), id, a, b, r, o, u, k);
    end

    // Contended stream: grants and responses must alternate starting at 0.
    for (int i = 0; i < 4; i++) begin gq[i] = -1; rq[i] = -1; resq[i] = 32'd0; end
    ng = 0; nr = 0;
    req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    req1_a = 32'h3FC0_0000; req1_b = 32'hBF80_0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 200 && nr < 4; c++) begin
      #1;
      if (ng < 4 && (req0_ready || req1_ready)) begin
        check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
        gq[ng] = req1_ready ? 1 : 0;
        ng++;
      end
      if (rsp_valid) begin
        rq[nr] = int'(rsp_id);
        resq[nr] = rsp_result;
        nr++;
      end
      @(negedge clk);
      if (ng == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d", i), 32'(gq[i]), 32'(i % 2));
      check($sformatf("rr_id%0d", i), 32'(rq[i]), 32'(i % 2));
      check($sformatf("rr_res%0d", i), resq[i], (i % 2 == 1) ? 32'h3F00_0000 : 32'h4000_0000);
    end
    @(negedge clk);

    // Held response: contended grant goes to requester 0, pointer moves to 1.
    rsp_ready = 1'b0;
    accept(1'b1, 1'b1, 32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, gid);
    check("hold_grant", 32'(gid), 32'd0);
    wait_rsp("hold", 32'h4080_0000, 1'b0, 1'b0, 0, 1'b0);
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold_res%0d", i), rsp_result, 32'h4080_0000);
      check($sformatf("hold_ctl%0d", i), {25'd0, rsp_valid, rsp_id, rsp_overflow,
            rsp_underflow, req0_ready, req1_ready, busy}, 32'b1000001);
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("hold_release", {30'd0, rsp_valid, busy}, 32'd0);
    @(negedge clk);

    // Long normalization from requester 1, then reset in the middle of NORM.
    accept(1'b0, 1'b1, 32'd0, 32'd0, 32'h3F80_0001, 32'hBF80_0000, gid);
    check("long_grant", 32'(gid), 32'd1);
    repeat (4) @(negedge clk);
    check("long_busy", 32'(busy), 32'd1);
    req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
    req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", {25'd0, rsp_valid, busy, req0_ready, req1_ready,
                         rsp_id, rsp_overflow, rsp_underflow}, 32'd0);
    check("midrst_res", rsp_result, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) hold_cnt++;
    end
    check("discarded", 32'(hold_cnt), 32'd0);
    accept(1'b1, 1'b1, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, gid);
    check("post_rst_grant", 32'(gid), 32'd0);
    wait_rsp("post_rst", 32'h4080_0000, 1'b0, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 SHALL have parameter PRIORITY_INIT, default 0, meaning the requester (0 or 1) favoured by round-robin after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester N has an operand pair.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1  requester N accepted this cycle when valid and ready are both high.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  normalized IEEE-754 single operands.
REQ-007 SHALL have port rsp_valid  output  1  result available.
REQ-008 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-009 SHALL have port rsp_result  output  32  IEEE-754 single sum.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns rsp_result.
REQ-011 SHALL have ports rsp_overflow, rsp_underflow  output  1  exception flags qualified by rsp_valid.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL sequence one shared iterative adder with FSM states IDLE, ALIGN, ADD, NORM, PACK, RESP.
REQ-014 SHALL raise readies only in IDLE and for at most one requester.
REQ-015 Arbitration: only one valid -> grant it; both valid -> grant the round-robin pointer, and the pointer then moves to the other requester.
REQ-016 SHALL latch both operands and the requester id on acceptance (cycle T) and go to ALIGN at T+1.
REQ-017 ALIGN: unpack with an implicit leading 1, right-shift the smaller-exponent mantissa by the exponent difference in one cycle, truncating; a difference above 24 makes it zero.
REQ-018 ADD: sign-magnitude add or subtract into a 25-bit magnitude; result sign is the sign of the larger magnitude (equal exponents: compare mantissas); a carry right-shifts once and increments the exponent.
REQ-019 NORM: one left shift and one exponent decrement per cycle until bit 23 is set; skipped when already normalized; a zero magnitude skips NORM.
REQ-020 Latency: rsp_valid rises at T+4+k, where k is the number of NORM cycles (0..23).
REQ-021 An exact-zero magnitude SHALL give 0x00000000 with no flags.
REQ-022 A result exponent >= 255 SHALL give sign|0x7F800000 with rsp_overflow=1.
REQ-023 A result exponent <= 0 SHALL give the signed zero with rsp_underflow=1.
REQ-024 An operand with exponent 0 SHALL be treated as zero; an operand with exponent 255 SHALL force the overflow result with that operand's sign.
REQ-025 RESP SHALL hold rsp_valid and all rsp_* outputs stable until rsp_ready, then return to IDLE the next cycle; a new grant is possible no earlier than that IDLE cycle.
REQ-026 Rounding SHALL be truncation (round toward zero).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, the pointer to PRIORITY_INIT, and rsp_valid, readies, busy, flags, rsp_id and rsp_result to 0, including mid-operation; the in-flight operation SHALL be discarded with no response.

Structure
REQ-028 The state enum, the exponent bias (127), the exponent-max (255) and the canonical constants (+0, +inf) SHALL live in shared package fp_pkg.
REQ-029 The ALIGN/ADD/NORM datapath registers SHALL be a sub-module fp_add_core with start/step control driven by the FSM; the arbiter and FSM stay in fp_add_arbiter.

Verification
REQ-030 req0 0x3F800000+0x3F800000 -> 0x40000000 via the carry path, rsp_valid at T+4, rsp_id=0.
REQ-031 req1 0x3FC00000+0xBF800000 -> 0x3F000000 with k=1, rsp_valid at T+5; and 0x3F800000+0xBF800000 -> 0x00000000 with no flags.
REQ-032 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000 with overflow=1; 0x00800000+0x80C00000 -> 0x80000000 with underflow=1.
REQ-033 Both valid continuously, PRIORITY_INIT=0, rsp_ready=1 -> grants and rsp_id sequence 0,1,0,1.
REQ-034 rsp_ready held low 3 cycles -> outputs stable, readies low; then rst_n pulsed during NORM -> immediate IDLE, no rsp_valid, next grant goes to PRIORITY_INIT.
